// File: rtl/dcc_bus_arb_if.sv
// Bus-request handshake between the DCC external masters, the main CPU and dcc_bus_arb.
// The arbiter uses the slave modport; the requesters/CPU side uses master.
interface dcc_bus_arb_if #(
    parameter int NCH = 2,
    parameter int OW  = (NCH > 1) ? $clog2(NCH) : 1
);
    logic [NCH-1:0] breq_n;
    logic [NCH-1:0] back_n;
    logic [NCH-1:0] preempt_n;
    logic           brls_n;
    logic           bgr_n;
    logic [OW-1:0]  owner;
    logic           busy;

    modport master (
        output breq_n, bgr_n,
        input  back_n, preempt_n, brls_n, owner, busy
    );

    modport slave (
        input  breq_n, bgr_n,
        output back_n, preempt_n, brls_n, owner, busy
    );
endinterface

// File: rtl/dcc_bus_arb.sv
// N-channel bus-request arbiter: merges active-low requests into one CPU release request,
// routes the CPU grant back to the latched winner, with optional round-robin and tenure limit.
//   state | meaning
//   IDLE  | no owner, waiting for any request
//   REQ   | winner latched, BRLS_N low, waiting for grant
//   OWN   | grant held by owner, tenure counting
//   REL   | owner released, waiting for CPU to drop grant
module dcc_bus_arb #(
    parameter int NCH         = 2,
    parameter int ROUND_ROBIN = 0,
    parameter int TENURE_W    = 8,
    parameter int TENURE_MAX  = 0
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_ce_r,
    input  logic           i_res_n,
    dcc_bus_arb_if.slave   bus
);
    localparam int OW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [TENURE_W-1:0] CNT_TOP = (TENURE_MAX == 0) ? {TENURE_W{1'b1}}
                                                                : TENURE_W'(TENURE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_OWN, S_REL} state_t;

    state_t              r_state;
    logic [OW-1:0]       r_owner;
    logic [OW-1:0]       r_last;
    logic [TENURE_W-1:0] r_cnt;
    logic                r_brls_n;
    logic [NCH-1:0]      r_preempt_n;

    logic [NCH-1:0]      w_req;
    logic [NCH-1:0]      w_above_last;
    logic [NCH-1:0]      w_own_oh;
    logic [OW-1:0]       w_win;
    logic [TENURE_W-1:0] w_cnt_inc;
    logic                w_others;
    logic                w_pre_hit;
    logic                w_owner_req_n;
    logic [NCH-1:0]      w_back_n;

    function automatic logic [OW-1:0] f_lowest(input logic [NCH-1:0] v);
        f_lowest = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) f_lowest = OW'(i);
        end
    endfunction

    // Round-robin: prefer requesters above the last owner, otherwise wrap to the lowest.
    always_comb begin
        w_req        = ~bus.breq_n;
        w_above_last = '0;
        for (int i = 0; i < NCH; i++) begin
            w_above_last[i] = (OW'(i) > r_last);
        end
        if ((ROUND_ROBIN != 0) && (|(w_req & w_above_last)))
            w_win = f_lowest(w_req & w_above_last);
        else
            w_win = f_lowest(w_req);
    end

    assign w_own_oh      = NCH'(1) << r_owner;
    assign w_owner_req_n = |(bus.breq_n & w_own_oh);
    assign w_others      = |(w_req & ~w_own_oh);
    assign w_cnt_inc     = (r_cnt == CNT_TOP) ? r_cnt : r_cnt + 1'b1;
    assign w_pre_hit     = (TENURE_MAX != 0) && (w_cnt_inc == CNT_TOP) && w_others;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_last      <= OW'(NCH - 1);
            r_cnt       <= '0;
            r_brls_n    <= 1'b1;
            r_preempt_n <= '1;
        end else if (!i_res_n) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_last      <= OW'(NCH - 1);
            r_cnt       <= '0;
            r_brls_n    <= 1'b1;
            r_preempt_n <= '1;
        end else if (i_ce_r) begin
            r_preempt_n <= '1;
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_state  <= S_REQ;
                        r_owner  <= w_win;
                        r_cnt    <= '0;
                        r_brls_n <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (w_owner_req_n) begin
                        r_state  <= S_IDLE;
                        r_brls_n <= 1'b1;
                    end else if (!bus.bgr_n) begin
                        r_state  <= S_OWN;
                    end
                end
                S_OWN: begin
                    r_cnt <= w_cnt_inc;
                    if (w_owner_req_n) begin
                        r_state  <= S_REL;
                        r_last   <= r_owner;
                        r_brls_n <= 1'b1;
                    end else if (w_pre_hit) begin
                        r_preempt_n <= ~w_own_oh;
                    end
                end
                S_REL: begin
                    if (bus.bgr_n) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Grant routing is combinational so the owner sees BGR_N without an extra tick.
    always_comb begin
        w_back_n = '1;
        if (((r_state == S_REQ) || (r_state == S_OWN)) && !bus.bgr_n)
            w_back_n = ~w_own_oh;
    end

    assign bus.back_n    = w_back_n;
    assign bus.preempt_n = r_preempt_n;
    assign bus.brls_n    = r_brls_n;
    assign bus.owner     = r_owner;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_dcc_bus_arb.sv
// Bench for dcc_bus_arb: three configurations driven side by side and compared each cycle
// against a behavioural model of the arbitration rules, plus directed scenario checks.
module tb_dcc_bus_arb;
    logic clk = 1'b0;
    logic rst_n, ce, res_n;
    logic [7:0] breq [3];
    logic       bgr  [3];

    logic       o_brls [3];
    logic       o_busy [3];
    logic [7:0] o_back [3];
    logic [7:0] o_pre  [3];
    logic [7:0] o_own  [3];

    int n_vec = 0;
    int n_err = 0;

    // configurations: u0 fixed NCH=2, u1 fixed NCH=4 tenure 4, u2 round-robin NCH=4
    int P_N   [3] = '{2, 4, 4};
    int P_RR  [3] = '{0, 0, 1};
    int P_TM  [3] = '{0, 4, 0};
    int P_CMX [3] = '{255, 255, 15};

    // model: phase 0 idle, 1 requesting, 2 owning, 3 releasing
    int         m_ph   [3];
    int         m_own  [3];
    int         m_last [3];
    int         m_cnt  [3];
    logic       m_brls [3];
    logic [7:0] m_pre  [3];

    always #5 clk = ~clk;

    dcc_bus_arb_if #(.NCH(2)) if_u0 ();
    dcc_bus_arb_if #(.NCH(4)) if_u1 ();
    dcc_bus_arb_if #(.NCH(4)) if_u2 ();

    dcc_bus_arb #(.NCH(2), .ROUND_ROBIN(0), .TENURE_W(8), .TENURE_MAX(0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce_r(ce), .i_res_n(res_n), .bus(if_u0.slave));
    dcc_bus_arb #(.NCH(4), .ROUND_ROBIN(0), .TENURE_W(8), .TENURE_MAX(4)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce_r(ce), .i_res_n(res_n), .bus(if_u1.slave));
    dcc_bus_arb #(.NCH(4), .ROUND_ROBIN(1), .TENURE_W(4), .TENURE_MAX(0)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce_r(ce), .i_res_n(res_n), .bus(if_u2.slave));

    assign if_u0.breq_n = breq[0][1:0];
    assign if_u1.breq_n = breq[1][3:0];
    assign if_u2.breq_n = breq[2][3:0];
    assign if_u0.bgr_n  = bgr[0];
    assign if_u1.bgr_n  = bgr[1];
    assign if_u2.bgr_n  = bgr[2];

    assign o_brls[0] = if_u0.brls_n;
    assign o_brls[1] = if_u1.brls_n;
    assign o_brls[2] = if_u2.brls_n;
    assign o_busy[0] = if_u0.busy;
    assign o_busy[1] = if_u1.busy;
    assign o_busy[2] = if_u2.busy;
    assign o_back[0] = 8'(if_u0.back_n);
    assign o_back[1] = 8'(if_u1.back_n);
    assign o_back[2] = 8'(if_u2.back_n);
    assign o_pre[0]  = 8'(if_u0.preempt_n);
    assign o_pre[1]  = 8'(if_u1.preempt_n);
    assign o_pre[2]  = 8'(if_u2.preempt_n);
    assign o_own[0]  = 8'(if_u0.owner);
    assign o_own[1]  = 8'(if_u1.owner);
    assign o_own[2]  = 8'(if_u2.owner);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] nmask(input int k);
        return 8'((1 << P_N[k]) - 1);
    endfunction

    function automatic int pick(input int k);
        int start = (P_RR[k] != 0) ? m_last[k] : P_N[k] - 1;
        for (int d = 1; d <= P_N[k]; d++) begin
            int c = (start + d) % P_N[k];
            if (!breq[k][c]) return c;
        end
        return 0;
    endfunction

    task automatic m_reset(input int k);
        m_ph[k] = 0; m_own[k] = 0; m_last[k] = P_N[k] - 1; m_cnt[k] = 0;
        m_brls[k] = 1'b1; m_pre[k] = nmask(k);
    endtask

    task automatic m_update(input int k);
        logic [7:0] req;
        int nph;
        int top;
        if (!rst_n || !res_n) begin
            m_reset(k);
            return;
        end
        if (!ce) return;
        req = ~breq[k] & nmask(k);
        nph = m_ph[k];
        top = (P_TM[k] != 0) ? P_TM[k] : P_CMX[k];
        m_pre[k] = nmask(k);
        if (m_ph[k] == 0) begin
            if (req != 0) begin m_own[k] = pick(k); m_cnt[k] = 0; nph = 1; end
        end else if (m_ph[k] == 1) begin
            if (breq[k][m_own[k]]) nph = 0;
            else if (!bgr[k]) nph = 2;
        end else if (m_ph[k] == 2) begin
            if (m_cnt[k] < top) m_cnt[k]++;
            if (breq[k][m_own[k]]) begin
                nph = 3; m_last[k] = m_own[k];
            end else if (P_TM[k] != 0 && m_cnt[k] == P_TM[k] &&
                         (req & ~(8'd1 << m_own[k])) != 0) begin
                m_pre[k][m_own[k]] = 1'b0;
            end
        end else begin
            if (bgr[k]) nph = 0;
        end
        m_ph[k]   = nph;
        m_brls[k] = !(nph == 1 || nph == 2);
    endtask

    task automatic m_check(input int k);
        logic [7:0] eb = nmask(k);
        if ((m_ph[k] == 1 || m_ph[k] == 2) && !bgr[k]) eb[m_own[k]] = 1'b0;
        chk($sformatf("u%0d brls_n", k), o_brls[k], m_brls[k]);
        chk($sformatf("u%0d back_n", k), o_back[k], eb);
        chk($sformatf("u%0d preempt_n", k), o_pre[k], m_pre[k]);
        chk($sformatf("u%0d busy", k), o_busy[k], m_ph[k] != 0);
        if (m_ph[k] != 0) chk($sformatf("u%0d owner", k), o_own[k], m_own[k]);
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic step();
        #1;
        for (int k = 0; k < 3; k++) m_check(k);
        @(posedge clk);
        for (int k = 0; k < 3; k++) m_update(k);
        @(negedge clk);
    endtask

    task automatic idle_all();
        ce = 1'b1; res_n = 1'b1;
        for (int k = 0; k < 3; k++) breq[k] = 8'hFF;
        step();
        for (int k = 0; k < 3; k++) bgr[k] = 1'b1;
        step();
        step();
    endtask

    task automatic rand_inputs();
        ce    = ($urandom_range(0, 4) != 0);
        res_n = ($urandom_range(0, 299) != 0);
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < P_N[k]; c++) begin
                if (breq[k][c]) begin
                    if ($urandom_range(0, 4) == 0) breq[k][c] = 1'b0;
                end else if (!m_pre[k][c]) begin
                    if ($urandom_range(0, 1) == 0) breq[k][c] = 1'b1;
                end else if ($urandom_range(0, 11) == 0) begin
                    breq[k][c] = 1'b1;
                end
            end
            if (!m_brls[k] && bgr[k]) begin
                if ($urandom_range(0, 2) == 0) bgr[k] = 1'b0;
            end else if (m_brls[k] && !bgr[k]) begin
                if ($urandom_range(0, 1) == 0) bgr[k] = 1'b1;
            end else if (!bgr[k] && $urandom_range(0, 99) == 0) begin
                bgr[k] = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; res_n = 1'b1;
        for (int k = 0; k < 3; k++) begin breq[k] = 8'hFF; bgr[k] = 1'b1; m_reset(k); end
        @(negedge clk);
        step();
        chk("rst brls_n", o_brls[1], 1'b1);
        chk("rst busy", o_busy[1], 1'b0);
        chk("rst owner", o_own[1], 0);
        rst_n = 1'b1;
        step();

        // both channels request: ch0 wins, then ch1 after ch0's tenure
        breq[0] = 8'hFC;
        step();
        chk("t1 owner", o_own[0], 0);
        chk("t1 brls_n", o_brls[0], 1'b0);
        bgr[0] = 1'b0;
        step();
        chk("t1 back_n ch0", o_back[0], 8'h02);
        breq[0] = 8'hFE & 8'hFD | 8'h01;
        step();
        bgr[0] = 1'b1;
        step();
        step();
        chk("t1 owner ch1", o_own[0], 1);
        bgr[0] = 1'b0;
        step();
        chk("t1 back_n ch1", o_back[0], 8'h01);
        idle_all();

        // round-robin with all four held low
        breq[2] = 8'hF0;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("t2 rr order", o_own[2], j % 4);
            bgr[2] = 1'b0;
            step();
            step();
            breq[2][j % 4] = 1'b1;
            step();
            bgr[2] = 1'b1;
            step();
            breq[2][j % 4] = 1'b0;
        end
        idle_all();

        // abort before grant
        breq[0] = 8'hFD;
        step();
        chk("t3 brls_n low", o_brls[0], 1'b0);
        breq[0] = 8'hFF;
        step();
        chk("t3 brls_n high", o_brls[0], 1'b1);
        chk("t3 back_n", o_back[0], 8'h03);
        chk("t3 busy", o_busy[0], 1'b0);

        // tenure expiry with a competing request
        breq[1] = 8'hFE;
        step();
        bgr[1] = 1'b0;
        step();
        breq[1] = 8'hFA;
        repeat (3) step();
        chk("t4 no preempt yet", o_pre[1], 8'h0F);
        step();
        chk("t4 preempt ch0", o_pre[1], 8'h0E);
        breq[1] = 8'hFB;
        step();
        chk("t4 preempt cleared", o_pre[1], 8'h0F);
        bgr[1] = 1'b1;
        step();
        step();
        chk("t4 owner ch2", o_own[1], 2);
        bgr[1] = 1'b0;
        step();
        chk("t4 back_n ch2", o_back[1], 8'h0B);
        idle_all();

        // soft reset mid-tenure; round-robin pointer must return to NCH-1
        breq[2] = 8'hFD;
        step();
        bgr[2] = 1'b0;
        step();
        breq[2] = 8'hFF;
        step();
        bgr[2] = 1'b1;
        step();
        breq[1] = 8'hFD; breq[2] = 8'hFB;
        step();
        step();
        bgr[1] = 1'b0; bgr[2] = 1'b0;
        step();
        ce = 1'b0; res_n = 1'b0;
        step();
        chk("t5 brls_n", o_brls[1], 1'b1);
        chk("t5 back_n", o_back[1], 8'h0F);
        chk("t5 busy", o_busy[1], 1'b0);
        ce = 1'b1; res_n = 1'b1;
        bgr[1] = 1'b1; bgr[2] = 1'b1; breq[1] = 8'hFF; breq[2] = 8'hF0;
        step();
        chk("t5 rr after res", o_own[2], 0);
        idle_all();

        // clock enable held off
        ce = 1'b0;
        breq[0] = 8'hFE;
        for (int j = 0; j < 10; j++) begin
            step();
            chk("t6 ce off brls_n", o_brls[0], 1'b1);
        end
        ce = 1'b1;
        step();
        chk("t6 ce on brls_n", o_brls[0], 1'b0);
        idle_all();

        for (int j = 0; j < 3000; j++) begin
            rand_inputs();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
